// File: rtl/bp_be_fe_queue_buffer.sv
// FE-to-BE queue buffer with speculative issue: entries stay held after issue
// until retired by deq_i, and roll_i rewinds the issue pointer for replay.
module bp_be_fe_queue_buffer #(
  parameter int els_p   = 8,
  parameter int width_p = 128
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic [width_p-1:0] data_i,
  input  logic               v_i,
  output logic               ready_o,
  output logic [width_p-1:0] data_o,
  output logic               v_o,
  input  logic               yumi_i,
  input  logic               clr_i,
  input  logic               roll_i,
  input  logic               deq_i,
  output logic               empty_o
);

  localparam int lg_els_lp = $clog2(els_p);

  // Index in the low bits, wrap bit on top; els_p is a power of two so +1 wraps for free.
  typedef logic [lg_els_lp:0] ptr_t;

  ptr_t               r_wptr, r_rptr, r_cptr;
  ptr_t               w_cptr_nxt;
  logic [width_p-1:0] r_mem [els_p];

  logic w_full, w_enq, w_yumi, w_deq;

  assign w_full  = (r_wptr[lg_els_lp-1:0] == r_cptr[lg_els_lp-1:0])
                && (r_wptr[lg_els_lp]     != r_cptr[lg_els_lp]);
  assign ready_o = ~w_full;
  assign v_o     = (r_rptr != r_wptr);
  assign data_o  = r_mem[r_rptr[lg_els_lp-1:0]];
  assign empty_o = (r_wptr == r_cptr);

  // Handshake qualifiers; reset and clear cancel any write into the array.
  assign w_enq  = v_i & ready_o & ~clr_i & reset_n_i;
  assign w_yumi = yumi_i & v_o;
  assign w_deq  = deq_i & (r_cptr != r_rptr);

  assign w_cptr_nxt = r_cptr + ptr_t'(w_deq);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i || clr_i) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cptr <= '0;
    end else begin
      r_wptr <= r_wptr + ptr_t'(w_enq);
      r_cptr <= w_cptr_nxt;
      // A replay restarts issue at the oldest entry still held after this cycle's retire.
      if (roll_i) r_rptr <= w_cptr_nxt;
      else        r_rptr <= r_rptr + ptr_t'(w_yumi);
    end
  end

  // NOTE: the storage array has no reset; pointers alone define which entries
  // are valid, so the array maps onto plain RAM without a clear path.
  always_ff @(posedge clk_i) begin
    if (w_enq) r_mem[r_wptr[lg_els_lp-1:0]] <= data_i;
  end

endmodule

// File: tb/tb_bp_be_fe_queue_buffer.sv
// Self-checking bench: directed scenarios with literal expectations plus a
// randomized run compared every cycle against a queue-based model.
module tb_bp_be_fe_queue_buffer;

  localparam int ELS = 4;
  localparam int W   = 16;

  logic         clk_i = 1'b0;
  logic         reset_n_i, v_i, yumi_i, clr_i, roll_i, deq_i;
  logic [W-1:0] data_i;
  logic         ready_o, v_o, empty_o;
  logic [W-1:0] data_o;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: entries held in age order, plus how many of the oldest have been issued.
  logic [W-1:0] held[$];
  int           issued   = 0;
  bit           model_ok = 1'b0;

  bp_be_fe_queue_buffer #(.els_p(ELS), .width_p(W)) dut (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .data_i    (data_i),
    .v_i       (v_i),
    .ready_o   (ready_o),
    .data_o    (data_o),
    .v_o       (v_o),
    .yumi_i    (yumi_i),
    .clr_i     (clr_i),
    .roll_i    (roll_i),
    .deq_i     (deq_i),
    .empty_o   (empty_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference behaviour, evaluated on the pre-edge state and inputs.
  always @(posedge clk_i) begin
    logic         do_enq, do_deq, do_yumi;
    logic [W-1:0] gone;
    if (!reset_n_i) begin
      held.delete();
      issued   = 0;
      model_ok = 1'b1;
    end else if (clr_i) begin
      held.delete();
      issued = 0;
    end else begin
      do_enq  = v_i && (held.size() < ELS);
      do_deq  = deq_i && (issued > 0);
      do_yumi = yumi_i && (issued < held.size());
      if (do_deq) begin
        gone = held.pop_front();
        issued--;
      end
      if (roll_i)       issued = 0;
      else if (do_yumi) issued++;
      if (do_enq) held.push_back(data_i);
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk_i) begin
    if (model_ok) begin
      check("v_o",     {31'b0, v_o},     {31'b0, issued < held.size()});
      check("ready_o", {31'b0, ready_o}, {31'b0, held.size() < ELS});
      check("empty_o", {31'b0, empty_o}, {31'b0, held.size() == 0});
      if (issued < held.size()) check("data_o", {16'b0, data_o}, {16'b0, held[issued]});
    end
  end

  task automatic cyc(input logic v, input logic [W-1:0] d, input logic y,
                     input logic c, input logic r, input logic dq, input logic rn);
    v_i = v; data_i = d; yumi_i = y; clr_i = c; roll_i = r; deq_i = dq; reset_n_i = rn;
    @(posedge clk_i);
    #1;
  endtask

  task automatic enq(input logic [W-1:0] d);
    cyc(1'b1, d, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic idle();
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic do_reset();
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    v_i = 0; data_i = '0; yumi_i = 0; clr_i = 0; roll_i = 0; deq_i = 0; reset_n_i = 0;
    do_reset();
    check("rst_v_o",     {31'b0, v_o},     32'd0);
    check("rst_ready_o", {31'b0, ready_o}, 32'd1);
    check("rst_empty_o", {31'b0, empty_o}, 32'd1);

    // Fill: A visible one cycle after enqueue, full after D, 5th rejected.
    enq(16'hA0A0);
    check("fill_v_after_A", {31'b0, v_o}, 32'd1);
    check("fill_data_A",    {16'b0, data_o}, 32'hA0A0);
    enq(16'hB1B1); enq(16'hC2C2); enq(16'hD3D3);
    check("fill_ready_after_D", {31'b0, ready_o}, 32'd0);
    enq(16'hEEEE);
    check("fill_5th_rejected", held.size(), 32'd4);
    check("fill_still_full",   {31'b0, ready_o}, 32'd0);

    // Issue all four, then deq+enq together while full: enqueue rejected.
    repeat (4) cyc(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    check("issued_all_v_o", {31'b0, v_o}, 32'd0);
    cyc(1'b1, 16'h5555, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    check("full_deq_ready", {31'b0, ready_o}, 32'd1);
    check("full_deq_v_o",   {31'b0, v_o}, 32'd0);
    check("full_deq_size",  held.size(), 32'd3);
    enq(16'hE4E4);
    check("wrap_v_o",    {31'b0, v_o}, 32'd1);
    check("wrap_data_E", {16'b0, data_o}, 32'hE4E4);

    // Replay: issue A and B, roll back to A.
    do_reset();
    enq(16'h0A0A); enq(16'h0B0B);
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    check("roll_pre_v_o",  {31'b0, v_o}, 32'd0);
    check("roll_pre_empty", {31'b0, empty_o}, 32'd0);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    check("roll_v_o",    {31'b0, v_o}, 32'd1);
    check("roll_data_A", {16'b0, data_o}, 32'h0A0A);
    check("roll_empty",  {31'b0, empty_o}, 32'd0);

    // deq with roll: A retired, replay from B; extra deq ignored until B issues.
    cyc(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    enq(16'h0A0A); enq(16'h0B0B);
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    check("deqroll_data_B", {16'b0, data_o}, 32'h0B0B);
    check("deqroll_size",   held.size(), 32'd1);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    check("deq_ignored_v_o",   {31'b0, v_o}, 32'd1);
    check("deq_ignored_empty", {31'b0, empty_o}, 32'd0);
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    check("deq_after_issue_empty", {31'b0, empty_o}, 32'd1);

    // Clear discards a same-cycle enqueue.
    enq(16'h1111); enq(16'h2222);
    cyc(1'b1, 16'h3333, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    check("clr_v_o",   {31'b0, v_o}, 32'd0);
    check("clr_empty", {31'b0, empty_o}, 32'd1);
    check("clr_ready", {31'b0, ready_o}, 32'd1);
    idle();
    check("clr_C_absent", {31'b0, v_o}, 32'd0);

    // Reset with yumi: everything discarded, pointers back at 0.
    enq(16'h4444);
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("rst_mid_v_o",   {31'b0, v_o}, 32'd0);
    check("rst_mid_empty", {31'b0, empty_o}, 32'd1);
    check("rst_mid_ready", {31'b0, ready_o}, 32'd1);
    enq(16'h7777);
    check("rst_mid_reenq", {16'b0, data_o}, 32'h7777);

    // Randomized traffic checked by the per-cycle compare process.
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(99) < 60, W'($urandom), $urandom_range(99) < 50,
          $urandom_range(199) < 3, $urandom_range(99) < 6,
          $urandom_range(99) < 40, !($urandom_range(499) < 2));
    end
    idle();
    @(negedge clk_i);
    #1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
